mod_updown_counter: RTL and testbench
=====================================

Name: mod_updown_counter

Overview:
Parametrised successor to the team's free-running 4-bit counter. Modulo-N up/down counter with enable, prescaled stepping, parallel load, synchronous clear, and wrap or saturate mode. It also produces terminal-count, event-pulse and sticky-overflow status. It is used as the general timing/event counter in the counters library and directly replaces the fixed 4-bit counter when the defaults are used.

Parameters:
WIDTH, 4, count register width in bits
MODULUS, 16, count range 0..MODULUS-1; legal range 2..2**WIDTH
PRESCALE, 1, enabled clock cycles per count step; 1 means step every enabled cycle; legal range 1..65535

Ports:
clk  in  1  system clock, all state updates on rising edge
res  in  1  asynchronous active-low reset
en  in  1  count enable; gates both the prescaler and stepping
clr  in  1  synchronous clear
load  in  1  synchronous parallel load
load_val  in  WIDTH  value to load
up  in  1  direction: 1 counts up, 0 counts down
sat  in  1  mode: 0 wraps, 1 saturates
count  out  WIDTH  current count value
tc  out  1  terminal count, combinational: (up & count==MODULUS-1) | (!up & count==0)
wrap_p  out  1  registered one-cycle pulse, high in the cycle after a wrap step
sat_p  out  1  registered one-cycle pulse, high in the cycle after a step blocked by saturation
ovf  out  1  sticky flag: set by any wrap or saturation event, cleared only by clr or res

Behaviour:
- Reset (res=0, asynchronous): count=0, prescaler=0, wrap_p=0, sat_p=0, ovf=0. All hold while res is low. First update is on the first rising clk edge after res rises.
- Priority per edge: clr > load > step > hold.
- clr: count=0, prescaler=0, ovf=0, wrap_p=0, sat_p=0. Ignores en.
- load: count = min(load_val, MODULUS-1); prescaler=0; wrap_p=sat_p=0; ovf unchanged. Ignores en.
- Prescaler: an internal counter runs 0..PRESCALE-1 and advances only when en=1. tick = en & (prescaler==PRESCALE-1); on tick the prescaler returns to 0. When PRESCALE=1, tick=en. When en=0, the prescaler holds its value (no reset).
- Step (on tick, no clr/load):
  - up, count<MODULUS-1: count+1.
  - up, count==MODULUS-1: sat=0 gives count=0 and wrap_p=1; sat=1 gives count held and sat_p=1.
  - down, count>0: count-1.
  - down, count==0: sat=0 gives count=MODULUS-1 and wrap_p=1; sat=1 gives count held and sat_p=1.
  - ovf is set on the same edge that sets wrap_p or sat_p.
- wrap_p and sat_p are 0 on every edge that does not generate them, so they can never be high for two cycles from one event. Consecutive events give consecutive pulses.
- Changing up or sat mid-count takes effect at the next tick. tc follows up combinationally.
- Arithmetic is unsigned WIDTH-bit. No intermediate value exceeds MODULUS-1. With MODULUS=2**WIDTH, wrap is natural roll-over but is still flagged.
- Latency: count changes one edge after the tick-qualifying cycle. Pulses appear on the same edge as the count change.
- Out-of-range parameters are caught by an elaboration-time check and stop elaboration.

Decomposition:
- Shared package cnt_pkg: direction constants CNT_UP=1 and CNT_DN=0; mode constants CNT_WRAP=0 and CNT_SAT=1; a function clog2 for the prescaler width.
- One sub-module, cnt_prescaler (param PRESCALE; ports clk, res, en, clr_i, tick), instantiated once. clr_i is driven by clr|load.
- The count datapath and status logic stay in mod_updown_counter.

Test Plan:
1. Defaults, res low for 10 ns then high, en=1, up=1, sat=0: count 0,1,..15,0 on successive edges; wrap_p high for exactly one cycle with count=0; ovf=1 afterwards; tc=1 while count=15.
2. MODULUS=10, up=0, sat=1, load_val=2 loaded, then en=1: count 2,1,0,0,0; sat_p pulses each cycle count is held at 0; wrap_p stays 0; ovf=1; tc=1 at 0.
3. MODULUS=10, up=0, sat=0 from count 0: next count=9 with wrap_p=1. load_val=13 gives count=9 (clamped).
4. PRESCALE=3, en=1: count increments every 3rd edge. Dropping en for 5 cycles mid-interval freezes both count and prescaler phase; stepping resumes after the remaining enabled cycles.
5. clr, load and tick asserted on the same edge with count=7: count=0 and ovf=0 (clr wins). With load and tick only, load_val=4 gives count=4 and no step.
6. Drop res asynchronously mid-cycle at count=9 with ovf=1: count=0 and ovf=0 immediately, without waiting for a clk edge. Counting restarts from 0 on the first edge after res rises.

Source files
------------

// File: rtl/cnt_pkg.sv
// Shared constants and helpers for the counters library.
// Direction/mode encodings and a width helper for sizing internal counters.
package cnt_pkg;

   localparam logic CNT_UP   = 1'b1;
   localparam logic CNT_DN   = 1'b0;
   localparam logic CNT_WRAP = 1'b0;
   localparam logic CNT_SAT  = 1'b1;

   // Bits needed to hold 0..v-1; never less than one bit.
   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      int unsigned x;
      r = 0;
      x = (v > 0) ? v - 1 : 0;
      while (x > 0) begin
         r = r + 1;
         x = x >> 1;
      end
      if (r == 0) begin
         r = 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/cnt_prescaler.sv
// Enable-gated prescaler: emits a one-cycle tick every PRESCALE enabled cycles.
// Holds its phase while en is low; clr_i returns it to phase 0.
module cnt_prescaler
   import cnt_pkg::*;
#(
   parameter int unsigned PRESCALE = 1
) (
   input  logic clk,
   input  logic res,
   input  logic en,
   input  logic clr_i,
   output logic tick
);

   localparam int unsigned PW = clog2(PRESCALE);
   localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

   logic [PW-1:0] pre_q;
   logic [PW-1:0] pre_d;

   // With PRESCALE=1 the register stays at 0 and tick reduces to en.
   assign tick = en & (pre_q == LAST);

   always_comb begin
      pre_d = pre_q;
      if (clr_i) begin
         pre_d = '0;
      end else if (en) begin
         pre_d = tick ? '0 : pre_q + PW'(1);
      end
   end

   always_ff @(posedge clk or negedge res) begin
      if (!res) begin
         pre_q <= '0;
      end else begin
         pre_q <= pre_d;
      end
   end

endmodule

// File: rtl/mod_updown_counter.sv
// Modulo-N up/down counter with prescaled stepping, load, clear, wrap/saturate
// mode, terminal count, wrap/saturation pulses and a sticky overflow flag.
module mod_updown_counter
   import cnt_pkg::*;
#(
   parameter int unsigned WIDTH    = 4,
   parameter int unsigned MODULUS  = 16,
   parameter int unsigned PRESCALE = 1
) (
   input  logic             clk,
   input  logic             res,
   input  logic             en,
   input  logic             clr,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             up,
   input  logic             sat,
   output logic [WIDTH-1:0] count,
   output logic             tc,
   output logic             wrap_p,
   output logic             sat_p,
   output logic             ovf
);

   if (WIDTH < 1 || WIDTH > 31 || MODULUS < 2 || longint'(MODULUS) > (64'd1 << WIDTH) ||
       PRESCALE < 1 || PRESCALE > 65535) begin : g_bad_param
      $fatal(1, "mod_updown_counter: illegal WIDTH/MODULUS/PRESCALE combination");
   end

   localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 1);

   logic [WIDTH-1:0] count_q, count_d;
   logic             wrap_q, wrap_d;
   logic             sat_q, sat_d;
   logic             ovf_q, ovf_d;
   logic             tick;

   cnt_prescaler #(
      .PRESCALE (PRESCALE)
   ) u_prescaler (
      .clk   (clk),
      .res   (res),
      .en    (en),
      .clr_i (clr | load),
      .tick  (tick)
   );

   // tc doubles as the "at the end of the range in this direction" condition.
   assign tc = (up == CNT_UP) ? (count_q == MAX) : (count_q == '0);

   always_comb begin
      count_d = count_q;
      wrap_d  = 1'b0;
      sat_d   = 1'b0;
      ovf_d   = ovf_q;
      if (clr) begin
         count_d = '0;
         ovf_d   = 1'b0;
      end else if (load) begin
         count_d = (load_val > MAX) ? MAX : load_val;
      end else if (tick) begin
         if (!tc) begin
            count_d = (up == CNT_UP) ? count_q + WIDTH'(1) : count_q - WIDTH'(1);
         end else if (sat == CNT_SAT) begin
            sat_d = 1'b1;
         end else begin
            count_d = (up == CNT_UP) ? '0 : MAX;
            wrap_d  = 1'b1;
         end
         ovf_d = ovf_q | wrap_d | sat_d;
      end
   end

   always_ff @(posedge clk or negedge res) begin
      if (!res) begin
         count_q <= '0;
         wrap_q  <= 1'b0;
         sat_q   <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         count_q <= count_d;
         wrap_q  <= wrap_d;
         sat_q   <= sat_d;
         ovf_q   <= ovf_d;
      end
   end

   assign count  = count_q;
   assign wrap_p = wrap_q;
   assign sat_p  = sat_q;
   assign ovf    = ovf_q;

endmodule

// File: tb/tb_mod_updown_counter.sv
// Bench for mod_updown_counter: three configurations share one stimulus stream
// and are checked each edge against a behavioural model via a scoreboard.
module tb_mod_updown_counter;

   typedef struct packed {
      logic [3:0] cnt;
      logic       wp;
      logic       sp;
      logic       ovf;
   } obs_t;
   typedef obs_t [2:0] trio_t;

   int unsigned mods [3] = '{16, 10, 16};
   int unsigned pres [3] = '{1, 1, 3};

   logic       clk = 1'b0;
   logic       res = 1'b0;
   logic       en = 1'b0;
   logic       clr = 1'b0;
   logic       load = 1'b0;
   logic       up = 1'b1;
   logic       sat = 1'b0;
   logic [3:0] load_val = 4'd0;

   logic [3:0] cnt_w [3];
   logic       tc_w  [3];
   logic       wp_w  [3];
   logic       sp_w  [3];
   logic       ovf_w [3];

   int unsigned m_cnt [3];
   int unsigned m_pre [3];
   logic        m_wp  [3];
   logic        m_sp  [3];
   logic        m_ovf [3];

   trio_t sb [$];
   int checks = 0;
   int errors = 0;

   mod_updown_counter #(.WIDTH(4), .MODULUS(16), .PRESCALE(1)) u_dut0 (
      .clk(clk), .res(res), .en(en), .clr(clr), .load(load), .load_val(load_val),
      .up(up), .sat(sat), .count(cnt_w[0]), .tc(tc_w[0]), .wrap_p(wp_w[0]),
      .sat_p(sp_w[0]), .ovf(ovf_w[0])
   );
   mod_updown_counter #(.WIDTH(4), .MODULUS(10), .PRESCALE(1)) u_dut1 (
      .clk(clk), .res(res), .en(en), .clr(clr), .load(load), .load_val(load_val),
      .up(up), .sat(sat), .count(cnt_w[1]), .tc(tc_w[1]), .wrap_p(wp_w[1]),
      .sat_p(sp_w[1]), .ovf(ovf_w[1])
   );
   mod_updown_counter #(.WIDTH(4), .MODULUS(16), .PRESCALE(3)) u_dut2 (
      .clk(clk), .res(res), .en(en), .clr(clr), .load(load), .load_val(load_val),
      .up(up), .sat(sat), .count(cnt_w[2]), .tc(tc_w[2]), .wrap_p(wp_w[2]),
      .sat_p(sp_w[2]), .ovf(ovf_w[2])
   );

   initial forever #5 clk = ~clk;

   task automatic check(input string tag, input int idx, input logic [3:0] obs,
                        input logic [3:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s dut%0d: observed %0d expected %0d", tag, idx, obs, exp);
      end
   endtask

   task automatic reset_model();
      for (int i = 0; i < 3; i++) begin
         m_cnt[i] = 0;
         m_pre[i] = 0;
         m_wp[i]  = 1'b0;
         m_sp[i]  = 1'b0;
         m_ovf[i] = 1'b0;
      end
   endtask

   // Predict the state after the coming edge from the current inputs.
   task automatic model_edge();
      trio_t e;
      bit    tick;
      for (int i = 0; i < 3; i++) begin
         m_wp[i] = 1'b0;
         m_sp[i] = 1'b0;
         if (clr) begin
            m_cnt[i] = 0;
            m_pre[i] = 0;
            m_ovf[i] = 1'b0;
         end else if (load) begin
            m_cnt[i] = (load_val > mods[i] - 1) ? mods[i] - 1 : load_val;
            m_pre[i] = 0;
         end else if (en) begin
            tick = (m_pre[i] == pres[i] - 1);
            m_pre[i] = tick ? 0 : m_pre[i] + 1;
            if (tick) begin
               if (up) begin
                  if (m_cnt[i] < mods[i] - 1) m_cnt[i]++;
                  else if (sat) m_sp[i] = 1'b1;
                  else begin m_cnt[i] = 0; m_wp[i] = 1'b1; end
               end else begin
                  if (m_cnt[i] > 0) m_cnt[i]--;
                  else if (sat) m_sp[i] = 1'b1;
                  else begin m_cnt[i] = mods[i] - 1; m_wp[i] = 1'b1; end
               end
               if (m_wp[i] || m_sp[i]) m_ovf[i] = 1'b1;
            end
         end
         e[i].cnt = 4'(m_cnt[i]);
         e[i].wp  = m_wp[i];
         e[i].sp  = m_sp[i];
         e[i].ovf = m_ovf[i];
      end
      sb.push_back(e);
   endtask

   task automatic step(input string tag);
      trio_t e;
      logic  exp_tc;
      model_edge();
      @(posedge clk);
      #1;
      e = sb.pop_front();
      for (int i = 0; i < 3; i++) begin
         exp_tc = (up && e[i].cnt == 4'(mods[i] - 1)) || (!up && e[i].cnt == 4'd0);
         check({tag, ".count"}, i, cnt_w[i], e[i].cnt);
         check({tag, ".wrap_p"}, i, {3'b0, wp_w[i]}, {3'b0, e[i].wp});
         check({tag, ".sat_p"}, i, {3'b0, sp_w[i]}, {3'b0, e[i].sp});
         check({tag, ".ovf"}, i, {3'b0, ovf_w[i]}, {3'b0, e[i].ovf});
         check({tag, ".tc"}, i, {3'b0, tc_w[i]}, {3'b0, exp_tc});
      end
   endtask

   initial begin
      reset_model();
      #8;
      for (int i = 0; i < 3; i++) begin
         check("reset.count", i, cnt_w[i], 4'd0);
         check("reset.ovf", i, {3'b0, ovf_w[i]}, 4'd0);
         check("reset.wrap_p", i, {3'b0, wp_w[i]}, 4'd0);
      end
      #2;
      res = 1'b1;

      // Free-running wrap count.
      en = 1'b1; up = 1'b1; sat = 1'b0;
      repeat (15) step("p1");
      check("p1.at15", 0, cnt_w[0], 4'd15);
      check("p1.tc15", 0, {3'b0, tc_w[0]}, 4'd1);
      step("p1");
      check("p1.wrap_cnt", 0, cnt_w[0], 4'd0);
      check("p1.wrap_p", 0, {3'b0, wp_w[0]}, 4'd1);
      step("p1");
      check("p1.wrap_once", 0, {3'b0, wp_w[0]}, 4'd0);
      check("p1.ovf", 0, {3'b0, ovf_w[0]}, 4'd1);

      // Down count into saturation at 0.
      load = 1'b1; load_val = 4'd2; up = 1'b0; sat = 1'b1;
      step("p2_load");
      check("p2.loaded", 1, cnt_w[1], 4'd2);
      load = 1'b0;
      repeat (2) step("p2");
      check("p2.zero", 1, cnt_w[1], 4'd0);
      check("p2.no_sat_yet", 1, {3'b0, sp_w[1]}, 4'd0);
      step("p2");
      check("p2.held", 1, cnt_w[1], 4'd0);
      check("p2.sat_p", 1, {3'b0, sp_w[1]}, 4'd1);
      step("p2");
      check("p2.sat_p2", 1, {3'b0, sp_w[1]}, 4'd1);
      check("p2.no_wrap", 1, {3'b0, wp_w[1]}, 4'd0);

      // Down wrap from 0 to MODULUS-1, then clamped load.
      sat = 1'b0;
      step("p3");
      check("p3.wrap_to9", 1, cnt_w[1], 4'd9);
      check("p3.wrap_p", 1, {3'b0, wp_w[1]}, 4'd1);
      load = 1'b1; load_val = 4'd13;
      step("p3_load");
      check("p3.clamp", 1, cnt_w[1], 4'd9);
      check("p3.noclamp", 0, cnt_w[0], 4'd13);
      load = 1'b0;

      // Prescaler phase survives en low.
      clr = 1'b1;
      step("p4_clr");
      clr = 1'b0; up = 1'b1;
      repeat (3) step("p4");
      check("p4.first", 2, cnt_w[2], 4'd1);
      step("p4");
      en = 1'b0;
      repeat (5) step("p4_hold");
      check("p4.frozen", 2, cnt_w[2], 4'd1);
      en = 1'b1;
      step("p4");
      check("p4.no_step", 2, cnt_w[2], 4'd1);
      step("p4");
      check("p4.resume", 2, cnt_w[2], 4'd2);

      // Priority: clr over load over step.
      load = 1'b1; load_val = 4'd7;
      step("p5_load7");
      clr = 1'b1;
      step("p5_clr");
      check("p5.clr_cnt", 0, cnt_w[0], 4'd0);
      check("p5.clr_ovf", 0, {3'b0, ovf_w[0]}, 4'd0);
      clr = 1'b0; load_val = 4'd4;
      step("p5_load4");
      check("p5.load_wins", 0, cnt_w[0], 4'd4);
      load = 1'b0;

      // Asynchronous reset mid-cycle.
      load = 1'b1; load_val = 4'd15;
      step("p6_load");
      load = 1'b0;
      step("p6_wrap");
      repeat (9) step("p6");
      check("p6.at9", 0, cnt_w[0], 4'd9);
      check("p6.ovf_set", 0, {3'b0, ovf_w[0]}, 4'd1);
      #3;
      res = 1'b0;
      #1;
      for (int i = 0; i < 3; i++) begin
         check("p6.async_cnt", i, cnt_w[i], 4'd0);
         check("p6.async_ovf", i, {3'b0, ovf_w[i]}, 4'd0);
      end
      reset_model();
      #2;
      res = 1'b1;
      step("p6_restart");
      check("p6.restart", 0, cnt_w[0], 4'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
